// File: rtl/arith_result_fifo_if.sv
// rtl/arith_result_fifo_if.sv - push/pop handshake bundle for the arithmetic result FIFO
interface arith_result_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [1:0]                 in_op;
    logic [2*WIDTH-1:0]         in_result;
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 out_op;
    logic [2*WIDTH-1:0]         out_result;
    logic                       out_zero;
    logic                       out_carry;
    logic [$clog2(DEPTH):0]     out_count;
    logic [7:0]                 err_cnt;

    modport slave (
        input  in_valid, in_op, in_result, out_ready,
        output in_ready, out_valid, out_op, out_result, out_zero, out_carry,
               out_count, err_cnt
    );

    modport master (
        output in_valid, in_op, in_result, out_ready,
        input  in_ready, out_valid, out_op, out_result, out_zero, out_carry,
               out_count, err_cnt
    );
endinterface

// File: rtl/arith_result_fifo.sv
// rtl/arith_result_fifo.sv - capture FIFO for ALU {op,result} with precomputed flags
module arith_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    arith_result_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ILL = 2'b11;

    logic [1:0]         mem_op     [DEPTH];
    logic [2*WIDTH-1:0] mem_result [DEPTH];
    logic               mem_zero   [DEPTH];
    logic               mem_carry  [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [7:0]    err_q;

    logic push;
    logic push_store;
    logic push_illegal;
    logic pop;
    logic not_empty;
    logic in_zero;
    logic in_carry;

    // in_ready depends on the registered count only, so a pop while full
    // cannot open the door for a push in the same cycle.
    assign bus.in_ready = (count != CW'(DEPTH));
    assign not_empty    = (count != '0);

    assign push         = bus.in_valid && bus.in_ready;
    assign push_illegal = push && (bus.in_op == OP_ILL);
    assign push_store   = push && (bus.in_op != OP_ILL);
    assign pop          = not_empty && bus.out_ready;

    always_comb begin
        in_zero  = (bus.in_result == '0);
        in_carry = 1'b0;
        if (bus.in_op == OP_ADD) begin
            in_carry = bus.in_result[WIDTH];
        end else if (bus.in_op == OP_SUB) begin
            in_carry = bus.in_result[2*WIDTH-1];
        end
    end

    // Storage is not reset; stale entries are never visible because the
    // outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem_op[wptr]     <= bus.in_op;
            mem_result[wptr] <= bus.in_result;
            mem_zero[wptr]   <= in_zero;
            mem_carry[wptr]  <= in_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            err_q <= '0;
        end else begin
            if (push_store) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push_store && !pop) begin
                count <= count + CW'(1);
            end else if (!push_store && pop) begin
                count <= count - CW'(1);
            end
            if (push_illegal && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign bus.out_valid  = not_empty;
    assign bus.out_count  = count;
    assign bus.err_cnt    = err_q;
    assign bus.out_op     = not_empty ? mem_op[rptr]     : 2'b00;
    assign bus.out_result = not_empty ? mem_result[rptr] : '0;
    assign bus.out_zero   = not_empty ? mem_zero[rptr]   : 1'b0;
    assign bus.out_carry  = not_empty ? mem_carry[rptr]  : 1'b0;
endmodule

// File: tb/tb_arith_result_fifo.sv
// tb/tb_arith_result_fifo.sv - directed and random checks of arith_result_fifo against a queue model
module tb_arith_result_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arith_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    arith_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    string tag = "init";

    logic [17:0] q[$];
    int model_err = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, name, obs, exp);
        end
    endtask

    function automatic logic carry_of(input logic [1:0] op, input logic [15:0] res);
        if (op == 2'd0) return res[WIDTH];
        if (op == 2'd1) return res[2*WIDTH-1];
        return 1'b0;
    endfunction

    task automatic check_all();
        logic [1:0]  eop;
        logic [15:0] eres;
        logic        ez;
        logic        ec;
        if (q.size() != 0) begin
            eop  = q[0][17:16];
            eres = q[0][15:0];
            ez   = (eres == 16'd0);
            ec   = carry_of(eop, eres);
        end else begin
            eop = 2'd0; eres = 16'd0; ez = 1'b0; ec = 1'b0;
        end
        check("out_valid",  32'(bus.out_valid),  32'(q.size() != 0));
        check("in_ready",   32'(bus.in_ready),   32'(q.size() != DEPTH));
        check("out_count",  32'(bus.out_count),  32'(q.size()));
        check("err_cnt",    32'(bus.err_cnt),    32'(model_err));
        check("out_op",     32'(bus.out_op),     32'(eop));
        check("out_result", 32'(bus.out_result), 32'(eres));
        check("out_zero",   32'(bus.out_zero),   32'(ez));
        check("out_carry",  32'(bus.out_carry),  32'(ec));
    endtask

    task automatic step(input logic rn, input logic v, input logic [1:0] op,
                        input logic [15:0] res, input logic rdy);
        bit do_push;
        bit do_pop;
        rst_n         = rn;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_result = res;
        bus.out_ready = rdy;
        do_push = v && (q.size() != DEPTH);
        do_pop  = rdy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (!rn) begin
            q.delete();
            model_err = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push && op == 2'd3) begin
                if (model_err < 255) model_err++;
            end else if (do_push) begin
                q.push_back({op, res});
            end
        end
        check_all();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_result = 16'd0; bus.out_ready = 1'b0;

        tag = "reset";
        step(1'b0, 1'b1, 2'd0, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 2'd0, 16'h1234, 1'b0);

        tag = "latency";
        step(1'b1, 1'b1, 2'd0, 16'h0100, 1'b0);
        check("carry_0100", 32'(bus.out_carry), 32'd1);
        step(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1);

        tag = "full";
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 2'd2, 16'(3 * i), 1'b0);
        check("full_count", 32'(bus.out_count), 32'd4);
        step(1'b1, 1'b1, 2'd2, 16'd99, 1'b1);
        check("after_full_pop", 32'(bus.out_result), 32'd6);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 16'd0, 1'b1);

        tag = "flags";
        step(1'b1, 1'b1, 2'd1, 16'hFFFF, 1'b0);
        check("sub_borrow", 32'(bus.out_carry), 32'd1);
        step(1'b1, 1'b1, 2'd0, 16'h0000, 1'b1);
        check("add_zero", 32'(bus.out_zero), 32'd1);
        step(1'b1, 1'b1, 2'd2, 16'h8000, 1'b1);
        check("mul_nocarry", 32'(bus.out_carry), 32'd0);
        step(1'b1, 1'b0, 2'd0, 16'd0, 1'b1);

        tag = "illegal";
        for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 2'd3, 16'($urandom), 1'b0);
        check("err_sat", 32'(bus.err_cnt), 32'd255);
        step(1'b1, 1'b1, 2'd0, 16'h0011, 1'b0);
        step(1'b1, 1'b1, 2'd1, 16'h0022, 1'b0);
        step(1'b1, 1'b1, 2'd3, 16'h0033, 1'b1);
        check("ill_pop_count", 32'(bus.out_count), 32'd1);

        tag = "random";
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 8 && q.size() != 3; i++) begin
            if (q.size() < 3) step(1'b1, 1'b1, 2'($urandom_range(0, 2)), 16'($urandom), 1'b0);
            else step(1'b1, 1'b0, 2'd0, 16'd0, 1'b1);
        end
        check("pre_reset_count", 32'(bus.out_count), 32'd3);

        tag = "midreset";
        step(1'b0, 1'b1, 2'd0, 16'h5555, 1'b1);
        check("post_reset_count", 32'(bus.out_count), 32'd0);
        step(1'b1, 1'b0, 2'd0, 16'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
